// File: rtl/test_status_monitor.sv
// End-of-test detector for riscv-tests programs: watches retiring PC and gp (x3)
// and reports sticky pass/fail/timeout. Optional macro ECALL_DETECT_EN adds ecall detection.
module test_status_monitor #(
  parameter logic [31:0] END_PC      = 32'h0000_0044,
  parameter int unsigned HOLD_CYCLES = 1,
  parameter int unsigned TIMEOUT     = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic        pc_valid,
  input  logic [31:0] pc,
  input  logic [31:0] gp,
  input  logic [31:0] instr,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [30:0] fail_testnum,
  output logic [31:0] cycles
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } state_t;

  localparam logic [31:0] HIT_LAST   = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] CYCLE_LAST = 32'(TIMEOUT - 1);
  localparam logic [31:0] ECALL_WORD = 32'h0000_0073;

  state_t      state;
  logic [31:0] hit_cnt;
  logic        end_hit;
  logic        term_event;
  logic        gp_is_one;

  assign end_hit   = pc_valid && (pc == END_PC);
  assign gp_is_one = (gp == 32'h0000_0001);

`ifdef ECALL_DETECT_EN
  // An ecall ends the test immediately, regardless of the END_PC hold count.
  assign term_event = (pc_valid && (instr == ECALL_WORD)) ||
                      (end_hit && (hit_cnt == HIT_LAST));
`else
  logic unused_instr;
  logic [31:0] unused_ecall;
  assign unused_instr = ^instr;
  assign unused_ecall = ECALL_WORD;
  assign term_event   = end_hit && (hit_cnt == HIT_LAST);
`endif

  // Cycles keep counting through the terminal-event cycle, then freeze;
  // a terminal event in the timeout cycle takes precedence over the timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_RUN;
      hit_cnt      <= '0;
      cycles       <= '0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      timeout      <= 1'b0;
      fail_testnum <= '0;
    end else if (arm) begin
      state        <= ST_RUN;
      hit_cnt      <= '0;
      cycles       <= '0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      timeout      <= 1'b0;
      fail_testnum <= '0;
    end else if (state == ST_RUN) begin
      if (cycles != 32'hFFFF_FFFF) begin
        cycles <= cycles + 32'd1;
      end
      if (end_hit) begin
        hit_cnt <= hit_cnt + 32'd1;
      end else if (pc_valid) begin
        hit_cnt <= '0;
      end
      if (term_event) begin
        done <= 1'b1;
        if (gp_is_one) begin
          state <= ST_PASS;
          pass  <= 1'b1;
        end else begin
          state        <= ST_FAIL;
          fail         <= 1'b1;
          fail_testnum <= gp[31:1];
        end
      end else if (cycles == CYCLE_LAST) begin
        state   <= ST_TIMEOUT;
        done    <= 1'b1;
        timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_test_status_monitor.sv
// Self-checking bench for test_status_monitor: directed scenarios plus randomized
// traffic on two instances (HOLD 1/TIMEOUT 20 and HOLD 3/TIMEOUT 64) against a model.
module tb_test_status_monitor;

  localparam int unsigned HOLD_A = 1;
  localparam int unsigned TMO_A  = 20;
  localparam int unsigned HOLD_B = 3;
  localparam int unsigned TMO_B  = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm = 1'b0;
  logic        pc_valid = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] gp = '0;
  logic [31:0] instr = '0;

  logic [1:0]  done_w, pass_w, fail_w, timeout_w;
  logic [30:0] testnum_w [2];
  logic [31:0] cycles_w  [2];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: status 0=running 1=pass 2=fail 3=timeout
  int          m_status  [2];
  longint      m_cycles  [2];
  int          m_streak  [2];
  logic [30:0] m_testnum [2];

  test_status_monitor #(.END_PC(32'h44), .HOLD_CYCLES(HOLD_A), .TIMEOUT(TMO_A)) dut_a (
    .clk(clk), .rst(rst), .arm(arm), .pc_valid(pc_valid), .pc(pc), .gp(gp), .instr(instr),
    .done(done_w[0]), .pass(pass_w[0]), .fail(fail_w[0]), .timeout(timeout_w[0]),
    .fail_testnum(testnum_w[0]), .cycles(cycles_w[0])
  );

  test_status_monitor #(.END_PC(32'h44), .HOLD_CYCLES(HOLD_B), .TIMEOUT(TMO_B)) dut_b (
    .clk(clk), .rst(rst), .arm(arm), .pc_valid(pc_valid), .pc(pc), .gp(gp), .instr(instr),
    .done(done_w[1]), .pass(pass_w[1]), .fail(fail_w[1]), .timeout(timeout_w[1]),
    .fail_testnum(testnum_w[1]), .cycles(cycles_w[1])
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_status[i]  = 0;
      m_cycles[i]  = 0;
      m_streak[i]  = 0;
      m_testnum[i] = '0;
    end
  endtask

  task automatic model_step();
    int unsigned hold;
    int unsigned tmo;
    bit is_end;
    bit is_ecall;
    bit terminal;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      hold = (i == 0) ? HOLD_A : HOLD_B;
      tmo  = (i == 0) ? TMO_A  : TMO_B;
      if (arm) begin
        m_status[i] = 0; m_cycles[i] = 0; m_streak[i] = 0; m_testnum[i] = '0;
        continue;
      end
      if (m_status[i] != 0) continue;
      is_end = pc_valid && (pc == 32'h44);
`ifdef ECALL_DETECT_EN
      is_ecall = pc_valid && (instr == 32'h73);
`else
      is_ecall = 1'b0;
`endif
      terminal = is_ecall || (is_end && (m_streak[i] + 1 >= int'(hold)));
      if (m_cycles[i] < 64'hFFFF_FFFF) m_cycles[i] = m_cycles[i] + 1;
      if (terminal) begin
        if (gp == 32'd1) m_status[i] = 1;
        else begin
          m_status[i]  = 2;
          m_testnum[i] = gp >> 1;
        end
      end else if (m_cycles[i] == longint'(tmo)) begin
        m_status[i] = 3;
      end
      if (is_end) m_streak[i] = m_streak[i] + 1;
      else if (pc_valid) m_streak[i] = 0;
    end
  endtask

  // Drive one cycle of inputs at the falling edge, clock it, then settle at the next falling edge.
  task automatic applyStimulus(input logic a, input logic v, input logic [31:0] p,
                               input logic [31:0] g, input logic [31:0] ins);
    arm = a; pc_valid = v; pc = p; gp = g; instr = ins;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    applyStimulus(1'b0, 1'b1, 32'h44, 32'h1, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h44, 32'h1, 32'h0);
    n_cmp++; if (done_w !== 2'b00) begin n_bad++; $display("[TB] FAIL reset_done: got %b want 00", done_w); end
    n_cmp++; if ({pass_w, fail_w, timeout_w} !== 6'b0) begin n_bad++; $display("[TB] FAIL reset_flags: got %b want 0", {pass_w, fail_w, timeout_w}); end
    n_cmp++; if (cycles_w[0] !== 32'd0) begin n_bad++; $display("[TB] FAIL reset_cycles: got %0d want 0", cycles_w[0]); end
    rst = 1'b0;
  endtask

  task automatic test_pass();
    for (int k = 0; k <= 16; k++) applyStimulus(1'b0, 1'b1, 32'(k * 4), 32'h0, 32'h13);
    n_cmp++; if (done_w[0] !== 1'b0) begin n_bad++; $display("[TB] FAIL pass_predone: got %b want 0", done_w[0]); end
    applyStimulus(1'b0, 1'b1, 32'h44, 32'h1, 32'h13);
    n_cmp++; if (pass_w[0] !== 1'b1) begin n_bad++; $display("[TB] FAIL pass_pass: got %b want 1", pass_w[0]); end
    n_cmp++; if (done_w[0] !== 1'b1) begin n_bad++; $display("[TB] FAIL pass_done: got %b want 1", done_w[0]); end
    n_cmp++; if ({fail_w[0], timeout_w[0]} !== 2'b00) begin n_bad++; $display("[TB] FAIL pass_others: got %b want 00", {fail_w[0], timeout_w[0]}); end
    n_cmp++; if (cycles_w[0] !== 32'd18) begin n_bad++; $display("[TB] FAIL pass_cycles: got %0d want 18", cycles_w[0]); end
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b1, 32'h48, 32'h9, 32'h13);
    n_cmp++; if (pass_w[0] !== 1'b1 || fail_w[0] !== 1'b0) begin n_bad++; $display("[TB] FAIL pass_sticky: got pass=%b fail=%b want 1/0", pass_w[0], fail_w[0]); end
    n_cmp++; if (cycles_w[0] !== 32'd18) begin n_bad++; $display("[TB] FAIL pass_frozen: got %0d want 18", cycles_w[0]); end
  endtask

  task automatic test_fail();
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    n_cmp++; if (done_w[0] !== 1'b0 || cycles_w[0] !== 32'd0) begin n_bad++; $display("[TB] FAIL arm_clear: got done=%b cycles=%0d want 0/0", done_w[0], cycles_w[0]); end
    applyStimulus(1'b0, 1'b1, 32'h44, 32'h7, 32'h0);
    n_cmp++; if (fail_w[0] !== 1'b1 || pass_w[0] !== 1'b0) begin n_bad++; $display("[TB] FAIL fail_flag: got fail=%b pass=%b want 1/0", fail_w[0], pass_w[0]); end
    n_cmp++; if (testnum_w[0] !== 31'd3) begin n_bad++; $display("[TB] FAIL fail_testnum: got %0d want 3", testnum_w[0]); end
    n_cmp++; if (cycles_w[0] !== 32'd1) begin n_bad++; $display("[TB] FAIL fail_cycles: got %0d want 1", cycles_w[0]); end
  endtask

  task automatic test_timeout();
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    for (int k = 0; k < 19; k++) applyStimulus(1'b0, 1'b1, 32'h10, 32'h1, 32'h13);
    n_cmp++; if (timeout_w[0] !== 1'b0) begin n_bad++; $display("[TB] FAIL tmo_early: got %b want 0", timeout_w[0]); end
    applyStimulus(1'b0, 1'b1, 32'h10, 32'h1, 32'h13);
    n_cmp++; if (timeout_w[0] !== 1'b1 || done_w[0] !== 1'b1) begin n_bad++; $display("[TB] FAIL tmo_flag: got tmo=%b done=%b want 1/1", timeout_w[0], done_w[0]); end
    n_cmp++; if (cycles_w[0] !== 32'd20) begin n_bad++; $display("[TB] FAIL tmo_cycles: got %0d want 20", cycles_w[0]); end
    applyStimulus(1'b0, 1'b1, 32'h44, 32'h1, 32'h13);
    n_cmp++; if (pass_w[0] !== 1'b0 || timeout_w[0] !== 1'b1) begin n_bad++; $display("[TB] FAIL tmo_sticky: got pass=%b tmo=%b want 0/1", pass_w[0], timeout_w[0]); end
  endtask

  task automatic test_hold();
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h44, 32'h1, 32'h13);
    applyStimulus(1'b0, 1'b1, 32'h44, 32'h1, 32'h13);
    applyStimulus(1'b0, 1'b1, 32'h40, 32'h1, 32'h13);
    applyStimulus(1'b0, 1'b1, 32'h44, 32'h1, 32'h13);
    applyStimulus(1'b0, 1'b0, 32'h44, 32'h1, 32'h13);
    applyStimulus(1'b0, 1'b1, 32'h44, 32'h1, 32'h13);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h1, 32'h13);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h1, 32'h13);
    n_cmp++; if (done_w[1] !== 1'b0) begin n_bad++; $display("[TB] FAIL hold_early: got %b want 0", done_w[1]); end
    applyStimulus(1'b0, 1'b1, 32'h44, 32'h1, 32'h13);
    n_cmp++; if (pass_w[1] !== 1'b1) begin n_bad++; $display("[TB] FAIL hold_pass: got %b want 1", pass_w[1]); end
    n_cmp++; if (cycles_w[1] !== 32'd9) begin n_bad++; $display("[TB] FAIL hold_cycles: got %0d want 9", cycles_w[1]); end
  endtask

  task automatic test_race_and_clear();
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    for (int k = 0; k < 19; k++) applyStimulus(1'b0, 1'b1, 32'h10, 32'h0, 32'h13);
    applyStimulus(1'b0, 1'b1, 32'h44, 32'h1, 32'h13);
    n_cmp++; if (pass_w[0] !== 1'b1 || timeout_w[0] !== 1'b0) begin n_bad++; $display("[TB] FAIL race_win: got pass=%b tmo=%b want 1/0", pass_w[0], timeout_w[0]); end
    n_cmp++; if (cycles_w[0] !== 32'd20) begin n_bad++; $display("[TB] FAIL race_cycles: got %0d want 20", cycles_w[0]); end
    applyStimulus(1'b1, 1'b1, 32'h44, 32'h1, 32'h13);
    n_cmp++; if (done_w !== 2'b00 || pass_w !== 2'b00) begin n_bad++; $display("[TB] FAIL arm_hit: got done=%b pass=%b want 00/00", done_w, pass_w); end
    n_cmp++; if (cycles_w[0] !== 32'd0) begin n_bad++; $display("[TB] FAIL arm_cycles: got %0d want 0", cycles_w[0]); end
    applyStimulus(1'b0, 1'b1, 32'h44, 32'h5, 32'h13);
    n_cmp++; if (fail_w[0] !== 1'b1 || testnum_w[0] !== 31'd2) begin n_bad++; $display("[TB] FAIL rst_pre: got fail=%b num=%0d want 1/2", fail_w[0], testnum_w[0]); end
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_cmp++; if (fail_w[0] !== 1'b0 || done_w[0] !== 1'b0 || testnum_w[0] !== 31'd0) begin n_bad++; $display("[TB] FAIL rst_async: got fail=%b done=%b num=%0d want 0", fail_w[0], done_w[0], testnum_w[0]); end
    n_cmp++; if (cycles_w[0] !== 32'd0) begin n_bad++; $display("[TB] FAIL rst_cycles: got %0d want 0", cycles_w[0]); end
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    rst = 1'b0;
  endtask

  task automatic test_ecall();
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h200, 32'h1, 32'h73);
`ifdef ECALL_DETECT_EN
    n_cmp++; if (pass_w !== 2'b11) begin n_bad++; $display("[TB] FAIL ecall_pass: got %b want 11", pass_w); end
`else
    n_cmp++; if (done_w !== 2'b00) begin n_bad++; $display("[TB] FAIL ecall_ignored: got %b want 00", done_w); end
`endif
  endtask

  task automatic test_random();
    logic        a, v;
    logic [31:0] p, g, ins;
    for (int n = 0; n < 3000; n++) begin
      a   = ($urandom_range(0, 39) == 0);
      v   = ($urandom_range(0, 3) != 0);
      p   = ($urandom_range(0, 2) == 0) ? 32'h44 : {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      g   = ($urandom_range(0, 1) == 0) ? 32'h1 : 32'($urandom);
      ins = ($urandom_range(0, 19) == 0) ? 32'h73 : 32'($urandom);
      applyStimulus(a, v, p, g, ins);
      for (int i = 0; i < 2; i++) begin
        n_cmp++; if (done_w[i] !== (m_status[i] != 0)) begin n_bad++; $display("[TB] FAIL rnd_done[%0d] @%0d: got %b want %b", i, n, done_w[i], m_status[i] != 0); end
        n_cmp++; if ({pass_w[i], fail_w[i], timeout_w[i]} !== {m_status[i] == 1, m_status[i] == 2, m_status[i] == 3}) begin n_bad++; $display("[TB] FAIL rnd_flags[%0d] @%0d: got %b%b%b want status %0d", i, n, pass_w[i], fail_w[i], timeout_w[i], m_status[i]); end
        n_cmp++; if (testnum_w[i] !== m_testnum[i]) begin n_bad++; $display("[TB] FAIL rnd_testnum[%0d] @%0d: got %0h want %0h", i, n, testnum_w[i], m_testnum[i]); end
        n_cmp++; if (cycles_w[i] !== 32'(m_cycles[i])) begin n_bad++; $display("[TB] FAIL rnd_cycles[%0d] @%0d: got %0d want %0d", i, n, cycles_w[i], m_cycles[i]); end
      end
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_pass();
    test_fail();
    test_timeout();
    test_hold();
    test_race_and_clear();
    test_ecall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
